// File: rtl/tick_prescaler.sv
// Programmable prescaler: emits a one-cycle tick every div_cur enabled cycles plus a 50%-duty clk_div.
// Single-cycle registered outputs; new divisors wait in a pending register until the next period boundary.
module tick_prescaler #(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 50000,
   parameter int MIN_DIV     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_value,
   output logic             tick,
   output logic             div_ack,
   output logic             clk_div,
   output logic [WIDTH-1:0] cnt,
   output logic [WIDTH-1:0] div_cur
);

   localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_DIV);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   logic             pend;
   logic [WIDTH-1:0] pend_val;
   logic [WIDTH-1:0] load_val;
   logic             wrap;

   assign load_val = (div_value < MIN_V) ? MIN_V : div_value;
   assign wrap     = enable && (cnt == div_cur - ONE_V);

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt      <= '0;
         tick     <= 1'b0;
         div_ack  <= 1'b0;
         clk_div  <= 1'b0;
         div_cur  <= DEF_V;
         pend     <= 1'b0;
         pend_val <= '0;
      end else begin
         tick    <= 1'b0;
         div_ack <= 1'b0;
         if (enable) begin
            if (wrap) begin
               cnt     <= '0;
               tick    <= 1'b1;
               clk_div <= ~clk_div;
               if (pend) begin
                  div_cur <= pend_val;
                  div_ack <= 1'b1;
                  pend    <= 1'b0;
               end
            end else begin
               cnt <= cnt + ONE_V;
            end
         end
         // A load on the wrap edge re-arms pend after the old value has been applied.
         if (div_load) begin
            pend_val <= load_val;
            pend     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tick_prescaler.sv
// Scoreboard bench for tick_prescaler (WIDTH=8, DEFAULT_DIV=5) with per-scenario tick/ack statistics.
module tb_tick_prescaler;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b0;
   logic         div_load = 1'b0;
   logic [W-1:0] div_value = '0;
   logic         tick, div_ack, clk_div;
   logic [W-1:0] cnt, div_cur;

   tick_prescaler #(.WIDTH(W), .DEFAULT_DIV(5), .MIN_DIV(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .div_load(div_load),
      .div_value(div_value), .tick(tick), .div_ack(div_ack),
      .clk_div(clk_div), .cnt(cnt), .div_cur(div_cur)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         tick;
      logic         ack;
      logic         cdiv;
      logic [W-1:0] cnt;
      logic [W-1:0] div;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;

   // reference model state
   logic [W-1:0] m_cnt = '0, m_div = 8'd5, m_pval = '0;
   logic         m_pend = 1'b0, m_clk = 1'b0;

   // per-scenario statistics
   int   steps, n_tick, n_ack, first_tick, n_double;
   logic prev_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      steps = 0; n_tick = 0; n_ack = 0; first_tick = -1; n_double = 0; prev_tick = 1'b0;
   endtask

   task automatic step(input logic r, input logic en, input logic ld, input logic [W-1:0] v);
      exp_t         e;
      logic         old_pend;
      logic [W-1:0] old_pval;
      @(negedge clk);
      reset = r; enable = en; div_load = ld; div_value = v;
      e = '0;
      if (r) begin
         m_cnt = '0; m_div = 8'd5; m_pend = 1'b0; m_pval = '0; m_clk = 1'b0;
      end else begin
         old_pend = m_pend;
         old_pval = m_pval;
         if (ld) begin
            m_pval = (v < 2) ? 8'd2 : v;
            m_pend = 1'b1;
         end
         if (en) begin
            if (m_cnt + 1 == m_div) begin
               m_cnt  = '0;
               e.tick = 1'b1;
               m_clk  = ~m_clk;
               if (old_pend) begin
                  m_div = old_pval;
                  e.ack = 1'b1;
                  if (!ld) m_pend = 1'b0;
               end
            end else begin
               m_cnt = m_cnt + 1;
            end
         end
      end
      e.cdiv = m_clk; e.cnt = m_cnt; e.div = m_div;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("tick",    tick,    e.tick);
      chk("div_ack", div_ack, e.ack);
      chk("clk_div", clk_div, e.cdiv);
      chk("cnt",     cnt,     e.cnt);
      chk("div_cur", div_cur, e.div);
      steps++;
      if (tick === 1'b1) begin
         n_tick++;
         if (first_tick < 0) first_tick = steps;
         if (prev_tick) n_double++;
      end
      if (div_ack === 1'b1) n_ack++;
      prev_tick = tick;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, '0);
      step(1'b1, 1'b0, 1'b0, '0);
      clr_stats();
   endtask

   initial begin
      // 1: steady enable
      do_reset();
      repeat (20) step(1'b0, 1'b1, 1'b0, '0);
      chk("t1_first_tick", first_tick, 5);
      chk("t1_ticks", n_tick, 4);
      chk("t1_double", n_double, 0);

      // 2: enable alternating
      do_reset();
      for (int i = 0; i < 40; i++) step(1'b0, (i % 2) == 0, 1'b0, '0);
      chk("t2_ticks", n_tick, 4);
      chk("t2_double", n_double, 0);

      // 3: load 3 at cnt=1
      do_reset();
      step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 8'd3);
      repeat (3) step(1'b0, 1'b1, 1'b0, '0);
      chk("t3_ack", n_ack, 1);
      chk("t3_tick", n_tick, 1);
      chk("t3_div", div_cur, 3);
      clr_stats();
      repeat (9) step(1'b0, 1'b1, 1'b0, '0);
      chk("t3_ticks_div3", n_tick, 3);
      chk("t3_no_ack", n_ack, 0);

      // 4a: load 0 clamps to 2
      do_reset();
      step(1'b0, 1'b1, 1'b1, 8'd0);
      repeat (4) step(1'b0, 1'b1, 1'b0, '0);
      chk("t4a_div", div_cur, 2);
      clr_stats();
      repeat (10) step(1'b0, 1'b1, 1'b0, '0);
      chk("t4a_ticks", n_tick, 5);

      // 4b: load 7 then 9 in one period
      do_reset();
      step(1'b0, 1'b1, 1'b1, 8'd7);
      step(1'b0, 1'b1, 1'b1, 8'd9);
      repeat (12) step(1'b0, 1'b1, 1'b0, '0);
      chk("t4b_ack", n_ack, 1);
      chk("t4b_div", div_cur, 9);
      chk("t4b_ticks", n_tick, 2);

      // 5: load on the wrap edge with nothing pending
      do_reset();
      repeat (4) step(1'b0, 1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 1'b1, 8'd4);
      chk("t5_wrap_tick", tick, 1);
      chk("t5_wrap_noack", div_ack, 0);
      chk("t5_div_hold", div_cur, 5);
      repeat (5) step(1'b0, 1'b1, 1'b0, '0);
      chk("t5_ack", n_ack, 1);
      chk("t5_div", div_cur, 4);

      // 6: pending load discarded by reset
      do_reset();
      step(1'b0, 1'b1, 1'b1, 8'd3);
      step(1'b0, 1'b1, 1'b0, '0);
      chk("t6_cnt_pre", cnt, 2);
      step(1'b1, 1'b1, 1'b0, '0);
      chk("t6_rst_cnt", cnt, 0);
      chk("t6_rst_div", div_cur, 5);
      clr_stats();
      repeat (20) step(1'b0, 1'b1, 1'b0, '0);
      chk("t6_no_ack", n_ack, 0);
      chk("t6_ticks", n_tick, 4);
      chk("t6_div", div_cur, 5);

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
